// File: rtl/note_player_if.sv
// Note-event handshake between a sequencer (master) and note_player (slave).
// An event transfers on any cycle where valid and ready are both high.
interface note_player_if;
   logic       note_valid_in;
   logic [5:0] note_index_in;
   logic [7:0] note_type_in;
   logic       note_ready_out;

   modport master (
      output note_valid_in,
      output note_index_in,
      output note_type_in,
      input  note_ready_out
   );

   modport slave (
      input  note_valid_in,
      input  note_index_in,
      input  note_type_in,
      output note_ready_out
   );
endinterface

// File: rtl/note_player.sv
// Queued square-wave note player: buffers note/rest events in a small FIFO and
// plays each one for units*EIGHTH_TICKS sample ticks at a tabulated pitch.
module note_player #(
   parameter int EIGHTH_TICKS = 2048,
   parameter int FS_HZ        = 8467,
   parameter int AMP          = 64,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic              clk_in,
   input  logic              rst_in,
   note_player_if.slave      note_if,
   input  logic              step_in,
   output logic signed [7:0] amp_out,
   output logic              playing_out,
   output logic              err_out
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(8 * EIGHTH_TICKS + 1);
   localparam logic signed [7:0] AMP_POS = 8'(AMP);
   localparam logic signed [7:0] AMP_NEG = 8'(-AMP);

   // Duration is stored as log2(units): eighth=0 .. whole=3.
   typedef struct packed {
      logic [5:0] idx;
      logic       rest;
      logic [1:0] dur_log;
   } event_t;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

   logic [15:0] w_inc_table [0:63];

   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_inc
         if (gi < 60) begin : g_note
            localparam int INC =
               $rtoi(65536.0 * 440.0 * (2.0 ** ((gi - 33) / 12.0)) / FS_HZ + 0.5);
            assign w_inc_table[gi] = 16'(INC);
         end else begin : g_silent
            assign w_inc_table[gi] = 16'd0;
         end
      end
   endgenerate

   event_t             r_mem [0:FIFO_DEPTH-1];
   event_t             r_head;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W:0]     r_count;
   logic               r_err;

   state_t             r_state;
   logic [15:0]        r_phase;
   logic [15:0]        r_inc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_rest;
   logic signed [7:0]  r_amp;
   logic               r_playing;

   logic               w_ready;
   logic               w_accept;
   logic               w_well_formed;
   logic               w_push;
   logic               w_pop;
   event_t             w_new_event;

   assign w_ready       = (r_count < (PTR_W + 1)'(FIFO_DEPTH));
   assign w_accept      = note_if.note_valid_in && w_ready && !rst_in;
   assign w_well_formed = $onehot(note_if.note_type_in);
   assign w_push        = w_accept && w_well_formed;
   assign w_pop         = (r_state == S_LOAD);

   assign w_new_event.idx     = note_if.note_index_in;
   assign w_new_event.rest    = (|note_if.note_type_in[7:4]) || (note_if.note_index_in >= 6'd60);
   assign w_new_event.dur_log = {note_if.note_type_in[2] | note_if.note_type_in[3] |
                                 note_if.note_type_in[6] | note_if.note_type_in[7],
                                 note_if.note_type_in[1] | note_if.note_type_in[3] |
                                 note_if.note_type_in[5] | note_if.note_type_in[7]};

   assign note_if.note_ready_out = w_ready;
   assign amp_out                = r_amp;
   assign playing_out            = r_playing;
   assign err_out                = r_err;

   // Storage with registered head read; r_head is valid by the time LOAD uses it.
   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_new_event;
      end
      r_head <= r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_err <= w_accept && !w_well_formed;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state   <= S_IDLE;
         r_phase   <= '0;
         r_inc     <= '0;
         r_cnt     <= '0;
         r_rest    <= 1'b0;
         r_amp     <= '0;
         r_playing <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (step_in) begin
                  r_amp <= '0;
               end
               if (r_count != '0) begin
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (step_in) begin
                  r_amp <= '0;
               end
               r_inc     <= w_inc_table[r_head.idx];
               r_rest    <= r_head.rest;
               r_cnt     <= CNT_W'(EIGHTH_TICKS) << r_head.dur_log;
               r_phase   <= '0;
               r_state   <= S_PLAY;
               r_playing <= 1'b1;
            end
            S_PLAY: begin
               // Output level comes from the phase before this tick's advance.
               if (step_in) begin
                  r_amp   <= r_rest ? 8'sd0 : (r_phase[15] ? AMP_NEG : AMP_POS);
                  r_phase <= r_phase + r_inc;
                  r_cnt   <= r_cnt - 1'b1;
                  if (r_cnt == CNT_W'(1)) begin
                     r_state   <= S_IDLE;
                     r_playing <= 1'b0;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_playing <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_player.sv
// Randomized scoreboard bench for note_player: a reference model expands each
// accepted event into its expected sample list; a monitor checks every tick.
module tb_note_player;

   localparam int ET          = 4;
   localparam int FS          = 8467;
   localparam int AMPL        = 64;
   localparam int DEPTH       = 8;
   localparam int STEP_PERIOD = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              step;
   logic signed [7:0] amp;
   logic              playing;
   logic              err;

   note_player_if nif ();

   note_player #(
      .EIGHTH_TICKS (ET),
      .FS_HZ        (FS),
      .AMP          (AMPL),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .note_if     (nif),
      .step_in     (step),
      .amp_out     (amp),
      .playing_out (playing),
      .err_out     (err)
   );

   always #5 clk = ~clk;

   int checks     = 0;
   int passed     = 0;
   int exp_q[$];
   int exp_err    = 0;
   int err_pulses = 0;
   int n_play     = 0;

   logic mon_s, mon_p, mon_r;
   int   mon_v;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Pitch from equal temperament around A4 = 440 Hz.
   function automatic int inc_of(int n);
      real f;
      f = 65536.0 * 440.0 * $pow(2.0, (n - 33) / 12.0) / FS;
      return $rtoi(f + 0.5);
   endfunction

   task automatic model_push(int idx, logic [7:0] t);
      int  pos = 0;
      int  units, n, inc, ph;
      bit  rest;
      for (int b = 0; b < 8; b++) if (t[b]) pos = b;
      units = 1 << (pos % 4);
      rest  = (pos >= 4) || (idx >= 60);
      n     = units * ET;
      inc   = rest ? 0 : inc_of(idx);
      for (int k = 0; k < n; k++) begin
         ph = (k * inc) % 65536;
         if (rest) exp_q.push_back(0);
         else      exp_q.push_back(ph >= 32768 ? -AMPL : AMPL);
      end
   endtask

   task automatic push(int idx, logic [7:0] t, bit exp_ready);
      bit bad;
      @(negedge clk);
      nif.note_valid_in = 1'b1;
      nif.note_index_in = idx[5:0];
      nif.note_type_in  = t;
      check("ready", int'(nif.note_ready_out), int'(exp_ready));
      bad = exp_ready && !$onehot(t);
      if (exp_ready) begin
         if ($onehot(t)) model_push(idx, t);
         else            exp_err++;
      end
      @(posedge clk);
      #1;
      nif.note_valid_in = 1'b0;
      check("err_next_cycle", int'(err), int'(bad));
   endtask

   task automatic drain();
      int budget = exp_q.size() * STEP_PERIOD + 200;
      int c = 0;
      while ((exp_q.size() != 0 || playing) && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("drain_in_time", (exp_q.size() != 0 || playing) ? 1 : 0, 0);
      repeat (2 * STEP_PERIOD) @(negedge clk);
   endtask

   initial begin
      step = 1'b0;
      forever begin
         repeat (STEP_PERIOD - 1) @(negedge clk);
         step = 1'b1;
         @(negedge clk);
         step = 1'b0;
      end
   end

   // Monitor: every tick yields one sample; ticks seen in PLAY consume the model queue.
   always @(posedge clk) begin
      mon_s = step;
      mon_p = playing;
      mon_r = rst;
      #1;
      if (err) err_pulses++;
      if (!mon_r && mon_s) begin
         if (mon_p) begin
            n_play++;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL sample_underflow: got %0d, expected no note sample", int'(amp));
            end else begin
               mon_v = exp_q.pop_front();
               check("note_sample", int'(amp), mon_v);
            end
         end else begin
            check("idle_sample", int'(amp), 0);
         end
      end
   end

   initial begin
      int base;
      int wait_c;
      int idx;
      logic [7:0] t;

      rst = 1'b1;
      nif.note_valid_in = 1'b0;
      nif.note_index_in = '0;
      nif.note_type_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_amp", int'(amp), 0);
      check("rst_playing", int'(playing), 0);
      check("rst_err", int'(err), 0);
      check("rst_ready", int'(nif.note_ready_out), 1);
      rst = 1'b0;

      // A4 eighth
      base = n_play;
      push(33, 8'h01, 1'b1);
      drain();
      check("eighth_play_ticks", n_play - base, 4 * ET / 4);

      // A4 whole: crosses into the negative half-cycle
      base = n_play;
      push(33, 8'h08, 1'b1);
      drain();
      check("whole_play_ticks", n_play - base, 8 * ET);

      // quarter rest then C2 eighth; out-of-range index plays silence
      push(12, 8'h20, 1'b1);
      push(0, 8'h01, 1'b1);
      push(61, 8'h02, 1'b1);
      drain();
      check("no_err_on_valid", err_pulses, exp_err);

      // Burst from IDLE: one entry is popped early, so the tenth push meets a full queue
      for (int i = 0; i < 10; i++) begin
         idx = int'($urandom_range(0, 59));
         t   = 8'(1 << $urandom_range(0, 3));
         push(idx, t, (i < 9) ? 1'b1 : 1'b0);
      end
      drain();

      // Malformed types are dropped
      push(33, 8'h03, 1'b1);
      push(33, 8'h00, 1'b1);
      drain();
      check("malformed_err_count", err_pulses, exp_err);

      // Reset during sample 2 of a half note with three events queued
      base = n_play;
      push(33, 8'h04, 1'b1);
      push(20, 8'h01, 1'b1);
      push(40, 8'h02, 1'b1);
      push(5, 8'h10, 1'b1);
      wait_c = 0;
      while (n_play < base + 2 && wait_c < 400) begin
         @(negedge clk);
         wait_c++;
      end
      check("reached_sample2", (n_play >= base + 2) ? 1 : 0, 1);
      @(negedge clk);
      rst = 1'b1;
      nif.note_valid_in = 1'b1;
      nif.note_index_in = 6'd33;
      nif.note_type_in  = 8'h01;
      exp_q.delete();
      @(negedge clk);
      check("midrst_amp", int'(amp), 0);
      check("midrst_playing", int'(playing), 0);
      check("midrst_ready", int'(nif.note_ready_out), 1);
      rst = 1'b0;
      nif.note_valid_in = 1'b0;
      base = n_play;
      repeat (20 * STEP_PERIOD) @(negedge clk);
      check("silent_after_rst", n_play - base, 0);

      // Randomized rounds, events may arrive mid-note
      for (int r = 0; r < 6; r++) begin
         for (int e = 0; e < int'($urandom_range(1, 4)); e++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            idx = int'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) t = 8'($urandom_range(0, 255));
            else                           t = 8'(1 << $urandom_range(0, 7));
            push(idx, t, 1'b1);
         end
         drain();
      end
      check("final_err_count", err_pulses, exp_err);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
